axi_s_m: RTL and testbench

Parameterised AXI-Stream master (transmitter) with an internal first-word-fall-through FIFO and packet framing. Upstream logic pushes bytes into the FIFO and requests a packet of a given beat count. The block then drives them onto an AXI-Stream link under `m_tready` backpressure and asserts `m_tlast` on the final beat. It is the transmit-side counterpart of the `axi_s_s` stream slave and connects directly to it.

---
 rtl/axi_s_m_if.sv | 9 +
 rtl/axi_s_m.sv | 65 ++++++
 tb/tb_axi_s_m.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_s_m_if.sv
// axi_s_m_if: AXI-Stream link (tvalid/tready/tdata/tlast) with master and slave modports
interface axi_s_m_if #(parameter int DATA_W = 8);
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  modport master(output m_tvalid, m_tdata, m_tlast, input m_tready);
  modport slave(input m_tvalid, m_tdata, m_tlast, output m_tready);
endinterface

// File: rtl/axi_s_m.sv
// axi_s_m: FWFT FIFO (wr_en/din/full) feeding a framed AXI-Stream master (start/pkt_len/busy/pkt_done, link m)
module axi_s_m #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              m_aclk,
  input  logic              m_areset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              busy,
  output logic              pkt_done,
  axi_s_m_if.master         m
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
  logic              pkt_done_q, wr, rd, launch;
  assign full     = count_q == (AW+1)'(DEPTH);
  assign wr       = wr_en && !full;
  assign rd       = m.m_tvalid && m.m_tready;
  assign launch   = state_q == IDLE && start && pkt_len != '0;
  assign pkt_done = pkt_done_q;
  always_ff @(posedge m_aclk or posedge m_areset)
    if (m_areset) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (launch ? SEND : IDLE) : (rd && m.m_tlast ? IDLE : SEND);
  always_comb begin
    busy       = state_q == SEND;
    m.m_tvalid = busy && count_q != '0;
    m.m_tlast  = m.m_tvalid && beat_q == len_q - 1'b1;
    m.m_tdata  = mem_q[rd_ptr_q];
  end
  always_comb begin
    count_d = wr && !rd ? count_q + 1'b1 : rd && !wr ? count_q - 1'b1 : count_q;
    len_d   = launch ? pkt_len : len_q;
    beat_d  = launch ? '0 : rd ? beat_q + 1'b1 : beat_q;
  end
  always_ff @(posedge m_aclk)
    if (wr) mem_q[wr_ptr_q] <= din;
  always_ff @(posedge m_aclk or posedge m_areset)
    if (m_areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q   <= rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q    <= count_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      pkt_done_q <= rd && m.m_tlast;
    end
endmodule

// File: tb/tb_axi_s_m.sv
// tb_axi_s_m: directed self-checking bench for axi_s_m
module tb_axi_s_m;
  logic       m_aclk = 1'b0;
  logic       m_areset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = '0;
  logic       full;
  logic       start = 1'b0;
  logic [7:0] pkt_len = '0;
  logic       busy;
  logic       pkt_done;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  axi_s_m_if #(.DATA_W(8)) bus();
  axi_s_m #(.DATA_W(8), .DEPTH(8), .LEN_W(8)) dut (
    .m_aclk(m_aclk), .m_areset(m_areset), .wr_en(wr_en), .din(din), .full(full),
    .start(start), .pkt_len(pkt_len), .busy(busy), .pkt_done(pkt_done), .m(bus)
  );
  always #5 m_aclk = ~m_aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge m_aclk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic send_pkt(input logic [7:0] len, input bit bp);
    int idx = 0;
    int c = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    start   = 1'b1;
    pkt_len = len;
    tick();
    start = 1'b0;
    while (idx < int'(len) && c < 200) begin
      bus.m_tready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      chk("busy_in_pkt", busy, 1);
      if (pv && !pr) begin
        chk("hold_valid", bus.m_tvalid, 1);
        chk("hold_data", bus.m_tdata, pd);
        chk("hold_last", bus.m_tlast, pl);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        chk("beat_data", bus.m_tdata, exp_q[idx]);
        chk("beat_last", bus.m_tlast, idx == int'(len) - 1);
        idx++;
      end
      pv = bus.m_tvalid;
      pr = bus.m_tready;
      pd = bus.m_tdata;
      pl = bus.m_tlast;
      tick();
      c++;
    end
    chk("beat_count", idx, len);
    chk("done_busy", busy, 0);
    chk("done_pulse", pkt_done, 1);
    chk("done_valid", bus.m_tvalid, 0);
    tick();
    chk("done_clear", pkt_done, 0);
    exp_q.delete();
  endtask
  initial begin
    bus.m_tready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.m_tvalid, 0);
    chk("rst_last", bus.m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_full", full, 0);
    m_areset = 1'b0;
    tick();
    chk("post_rst_full", full, 0);
    foreach (exp_q[i]) exp_q.delete();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) wr(exp_q[i]);
    chk("idle_valid", bus.m_tvalid, 0);
    send_pkt(4, 0);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) wr(exp_q[i]);
    send_pkt(4, 1);
    for (int i = 1; i <= 9; i++) begin
      wr(8'(i));
      if (i == 7) chk("not_full_7", full, 0);
      if (i >= 8) chk("full_after_8", full, 1);
    end
    chk("idle_full_valid", bus.m_tvalid, 0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(8, 0);
    chk("drained_full", full, 0);
    exp_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
    foreach (exp_q[i]) wr(exp_q[i]);
    chk("wrap_full", full, 1);
    send_pkt(8, 1);
    bus.m_tready = 1'b1;
    wr(8'hA1);
    start   = 1'b1;
    pkt_len = 8'd3;
    tick();
    start = 1'b0;
    chk("uf_b0_valid", bus.m_tvalid, 1);
    chk("uf_b0_data", bus.m_tdata, 8'hA1);
    chk("uf_b0_last", bus.m_tlast, 0);
    tick();
    chk("uf_empty_valid", bus.m_tvalid, 0);
    chk("uf_busy", busy, 1);
    start   = 1'b1;
    pkt_len = 8'd5;
    tick();
    start = 1'b0;
    chk("uf_still_empty", bus.m_tvalid, 0);
    wr(8'hA2);
    chk("uf_b1_valid", bus.m_tvalid, 1);
    chk("uf_b1_data", bus.m_tdata, 8'hA2);
    chk("uf_b1_last", bus.m_tlast, 0);
    wr(8'hA3);
    chk("uf_b2_data", bus.m_tdata, 8'hA3);
    chk("uf_b2_last", bus.m_tlast, 1);
    tick();
    chk("uf_done_busy", busy, 0);
    chk("uf_done_pulse", pkt_done, 1);
    wr(8'hB0);
    start   = 1'b1;
    pkt_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_len_busy", busy, 0);
    chk("zero_len_valid", bus.m_tvalid, 0);
    exp_q = '{8'hB0};
    send_pkt(1, 0);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    foreach (exp_q[i]) wr(exp_q[i]);
    start   = 1'b1;
    pkt_len = 8'd4;
    tick();
    start = 1'b0;
    chk("mr_b0_data", bus.m_tdata, 8'hC1);
    tick();
    chk("mr_b1_data", bus.m_tdata, 8'hC2);
    tick();
    chk("mr_b2_valid", bus.m_tvalid, 1);
    #2;
    m_areset = 1'b1;
    #1;
    chk("mr_async_valid", bus.m_tvalid, 0);
    chk("mr_async_last", bus.m_tlast, 0);
    chk("mr_async_busy", busy, 0);
    tick();
    chk("mr_full", full, 0);
    m_areset = 1'b0;
    tick();
    start   = 1'b1;
    pkt_len = 8'd1;
    tick();
    start = 1'b0;
    chk("mr_flushed_busy", busy, 1);
    chk("mr_flushed_valid", bus.m_tvalid, 0);
    wr(8'h5A);
    chk("one_valid", bus.m_tvalid, 1);
    chk("one_data", bus.m_tdata, 8'h5A);
    chk("one_last", bus.m_tlast, 1);
    tick();
    chk("one_done_busy", busy, 0);
    chk("one_done_pulse", pkt_done, 1);
    tick();
    chk("one_done_clear", pkt_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
